flex_pts_tx: RTL and testbench
==============================

Name: flex_pts_tx

Overview:
- Parametrised parallel-to-serial transmitter; next generation of the team's flex PTS shift register.
- Adds:
  - valid/ready load handshake
  - per-frame runtime bit order (MSB/LSB first)
  - one-word holding buffer for gapless back-to-back frames
  - bit counter, busy flag and frame-done strobe
- Sits between a parallel data producer (FIFO or controller) and a serial line driver.
- Bit timing comes from an external shift_enable tick, e.g. a baud-rate timer.

Parameters:
- NUM_BITS, 8: frame width in bits; must be >= 2.
- IDLE_VAL, 1'b1: level driven on serial_out when no frame is active.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- shift_enable  input  1  bit tick; advances one bit while a frame is active.
- in_valid  input  1  producer has a word on parallel_in.
- in_ready  output  1  block can accept a word this cycle.
- parallel_in  input  NUM_BITS  word to transmit.
- msb_first  input  1  bit order for the word being accepted (1 = MSB first).
- serial_out  output  1  registered serial data.
- busy  output  1  frame in progress (state SHIFT).
- frame_done  output  1  single-cycle pulse after the last bit of a frame.

Behaviour:
- Reset is asynchronous. Reset values:
  - serial_out = IDLE_VAL, busy = 0, frame_done = 0, in_ready = 1
  - state = IDLE, bit count = 0, holding buffer empty
- Reset mid-frame aborts the frame immediately. No frame_done is produced.
- Accept: occurs when in_valid && in_ready at a rising edge.
  - The word and msb_first are captured together.
  - Bit order is fixed per frame. Changing msb_first mid-frame has no effect on that frame.
- in_ready = !hold_full. It is combinational from registered state only and has no path from in_valid.
- State IDLE:
  - serial_out = IDLE_VAL.
  - shift_enable is ignored.
  - On accept, the word loads directly into the shift register and the count clears to 0.
  - At that same edge: state becomes SHIFT, serial_out becomes bit 0 of the frame (parallel_in[NUM_BITS-1] if msb_first, else parallel_in[0]), busy = 1.
  - Load-to-first-bit latency is 1 clock.
  - A shift_enable in the accept cycle does not advance the new frame.
- State SHIFT:
  - serial_out holds the current bit until the next shift_enable.
  - shift_enable with count < NUM_BITS-1: serial_out takes the next bit in frame order and count increments.
  - shift_enable with count == NUM_BITS-1 (frame end): frame_done = 1 for exactly the following cycle. Then:
    - Hold full: the held word and its order load into the shift register; serial_out = its bit 0; count = 0; hold becomes empty; stay in SHIFT. There is no idle gap.
    - Hold empty and an accept occurs at the same edge: the incoming word bypasses hold and loads as above; stay in SHIFT.
    - Otherwise: state becomes IDLE, serial_out = IDLE_VAL, busy = 0.
  - Accept in SHIFT, not at frame end: the word goes to the holding buffer; hold_full = 1, so in_ready = 0 from the next cycle.
- Each frame emits exactly NUM_BITS bits. Each bit is held from one shift_enable to the next; the last bit is held until the frame-end tick.
- The count is $clog2(NUM_BITS) bits wide and never exceeds NUM_BITS-1.
- All outputs except in_ready are registered.

Decomposition:
- Package flex_pts_pkg holds:
  - enum state_t {IDLE, SHIFT}
  - function first_bit(word, msb_first)
  - width helper localparam CNT_W = $clog2(NUM_BITS)
- Sub-module pts_bit_counter: parametrised up-counter with clear, enable and terminal-count flag at NUM_BITS-1.
- Shift register, holding buffer and FSM stay in flex_pts_tx.

Test Plan (NUM_BITS=8, IDLE_VAL=1, shift_enable every 4th cycle unless stated):
- Reset: assert n_rst=0 mid-frame -> serial_out=1, busy=0, in_ready=1 immediately. No frame_done after release.
- MSB-first frame: accept 8'hA5, msb_first=1 -> serial_out sequence 1,0,1,0,0,1,0,1. frame_done pulses once after 8th tick. Then serial_out=1, busy=0.
- LSB-first frame: accept 8'hA5, msb_first=0 -> sequence 1,0,1,0,0,1,0,1 reversed per bit index (bits 0..7 = 1,0,1,0,0,1,0,1). Toggling msb_first mid-frame has no effect.
- Back-to-back: accept 8'hF0 (MSB), then 8'h0F (LSB) during frame 1 -> in_ready drops after 2nd accept. Output 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0 with no idle cycle. Two frame_done pulses.
- Frame-end bypass: hold empty, accept 8'h81 exactly on the frame-end tick edge -> next frame starts the next cycle, serial_out=1, no IDLE_VAL gap.
- Ignored tick / accept-cycle tick: shift_enable held high in IDLE for 10 cycles -> serial_out stays 1. Accept with shift_enable=1 in the same cycle -> first bit still held until the next tick.

Source files
------------

// File: rtl/flex_pts_pkg.sv
// Shared types and helpers for the flex parallel-to-serial transmitter.
package flex_pts_pkg;

    // Two-state frame FSM: waiting for a word, or shifting one out.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Widest frame the first_bit helper can look at.
    localparam int MAX_W = 64;

    // Default frame width and the matching bit-count width.
    localparam int DEF_NUM_BITS = 8;
    localparam int CNT_W        = $clog2(DEF_NUM_BITS);

    // Bit-count width for an arbitrary frame width (frames are at least 2 bits).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // First bit on the line for a word of nbits: its top bit when MSB first,
    // otherwise bit 0. A shift keeps the index width independent of nbits.
    function automatic logic first_bit(input logic [MAX_W-1:0] word,
                                       input logic             msb_first,
                                       input int unsigned      nbits);
        logic [MAX_W-1:0] top;
        top = word >> (nbits - 1);
        return msb_first ? top[0] : word[0];
    endfunction

endpackage

// File: rtl/pts_bit_counter.sv
// Bit position counter for one frame: clears on load, counts on each
// shifted bit, and flags the last bit position (NUM_BITS-1).
module pts_bit_counter #(
    parameter int NUM_BITS = 8,
    parameter int CW       = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    logic [CW-1:0] r_count;

    assign o_terminal = (r_count == CW'(NUM_BITS - 1));

    // Clear wins over enable; the count saturates at the last bit position.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/flex_pts_tx.sv
// Parallel-to-serial transmitter with valid/ready load, per-frame bit order,
// a one-word holding buffer for gapless back-to-back frames, and a frame-done
// strobe.
//
// Handshake: a word is taken at a rising edge when in_valid && in_ready.
// in_ready depends only on the holding-buffer flag, never on in_valid.
// busy is the registered FSM state (1 = SHIFT), usable to observe the FSM.
module flex_pts_tx
    import flex_pts_pkg::*;
#(
    parameter int   NUM_BITS = 8,
    parameter logic IDLE_VAL = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] parallel_in,
    input  logic                msb_first,
    output logic                serial_out,
    output logic                busy,
    output logic                frame_done
);

    localparam int CW = cnt_width(NUM_BITS);

    state_t              r_state;
    state_t              w_next_state;
    logic [NUM_BITS-1:0] r_shift;
    logic                r_order;
    logic [NUM_BITS-1:0] r_hold;
    logic                r_hold_msb;
    logic                r_hold_full;
    logic                r_serial;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic                w_tick;
    logic                w_terminal;
    logic                w_frame_end;
    logic                w_advance;
    logic                w_load;
    logic                w_from_hold;
    logic                w_to_hold;
    logic [NUM_BITS-1:0] w_load_word;
    logic                w_load_msb;

    assign in_ready    = !r_hold_full;
    assign w_accept    = in_valid && !r_hold_full;
    assign w_tick      = (r_state == SHIFT) && shift_enable;
    assign w_frame_end = w_tick && w_terminal;
    assign w_advance   = w_tick && !w_terminal;

    assign w_load_word = w_from_hold ? r_hold : parallel_in;
    assign w_load_msb  = w_from_hold ? r_hold_msb : msb_first;

    pts_bit_counter #(
        .NUM_BITS (NUM_BITS),
        .CW       (CW)
    ) u_bit_counter (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_load || w_frame_end),
        .i_enable   (w_advance),
        .o_terminal (w_terminal)
    );

    // Decide what happens at this edge: load a frame, park a word, or go idle.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_from_hold  = 1'b0;
        w_to_hold    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_frame_end) begin
                    if (r_hold_full) begin
                        w_load      = 1'b1;
                        w_from_hold = 1'b1;
                    end else if (w_accept) begin
                        // Incoming word skips the buffer so the line never idles.
                        w_load = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (w_accept) begin
                    w_to_hold = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM state, busy flag and the one-cycle frame-done strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == SHIFT);
            r_done  <= w_frame_end;
        end
    end

    // Shift register and serial output; the word is kept in its original
    // order and shifted left or right according to the captured frame order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_shift  <= '0;
            r_order  <= 1'b1;
            r_serial <= IDLE_VAL;
        end else if (w_load) begin
            r_shift  <= w_load_word;
            r_order  <= w_load_msb;
            r_serial <= first_bit(MAX_W'(w_load_word), w_load_msb, NUM_BITS);
        end else if (w_advance) begin
            if (r_order) begin
                r_serial <= r_shift[NUM_BITS-2];
                r_shift  <= {r_shift[NUM_BITS-2:0], 1'b0};
            end else begin
                r_serial <= r_shift[1];
                r_shift  <= {1'b0, r_shift[NUM_BITS-1:1]};
            end
        end else if (w_next_state == IDLE) begin
            r_serial <= IDLE_VAL;
        end
    end

    // Holding buffer: fills on an accept mid-frame, drains at frame end.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_hold      <= '0;
            r_hold_msb  <= 1'b1;
            r_hold_full <= 1'b0;
        end else if (w_to_hold) begin
            r_hold      <= parallel_in;
            r_hold_msb  <= msb_first;
            r_hold_full <= 1'b1;
        end else if (w_from_hold) begin
            r_hold_full <= 1'b0;
        end
    end

    assign serial_out = r_serial;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule

// File: tb/tb_flex_pts_tx.sv
// Bench for flex_pts_tx (NUM_BITS=8, IDLE_VAL=1): frame table, directed
// multi-cycle corner cases, and a random phase against a frame-level model.
module tb_flex_pts_tx;

  localparam int N = 8;

  logic         clk;
  logic         n_rst;
  logic         shift_enable;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] parallel_in;
  logic         msb_first;
  logic         serial_out;
  logic         busy;
  logic         frame_done;

  int checks;
  int failures;
  int done_seen;

  flex_pts_tx #(
    .NUM_BITS (N),
    .IDLE_VAL (1'b1)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .parallel_in  (parallel_in),
    .msb_first    (msb_first),
    .serial_out   (serial_out),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- frame-level reference model ----------------
  // Current frame: a word, its order, and which bit of the frame is on the line.
  // Pending: at most one waiting word.
  bit           m_active;
  logic [N-1:0] m_word;
  bit           m_msb;
  int           m_idx;
  bit           m_pend;
  logic [N-1:0] m_pend_word;
  bit           m_pend_msb;
  bit           m_done;

  task automatic model_reset();
    m_active = 0;
    m_idx    = 0;
    m_pend   = 0;
    m_done   = 0;
  endtask

  function automatic logic model_serial();
    if (!m_active) return 1'b1;
    return m_msb ? m_word[N-1-m_idx] : m_word[m_idx];
  endfunction

  task automatic model_start(input logic [N-1:0] w, input bit m);
    m_active = 1;
    m_word   = w;
    m_msb    = m;
    m_idx    = 0;
  endtask

  task automatic model_step(input logic se, input logic v, input logic [N-1:0] d, input logic m);
    bit acc;
    acc    = v && !m_pend;
    m_done = 0;
    if (!m_active) begin
      if (acc) model_start(d, m);
    end else if (se && m_idx == N-1) begin
      m_done = 1;
      if (m_pend) begin
        model_start(m_pend_word, m_pend_msb);
        m_pend = 0;
      end else if (acc) begin
        model_start(d, m);
      end else begin
        m_active = 0;
      end
    end else begin
      if (se) m_idx++;
      if (acc) begin
        m_pend      = 1;
        m_pend_word = d;
        m_pend_msb  = m;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, let the DUT take it at the rising
  // edge, compare at the next falling edge.
  task automatic cyc(input logic se, input logic v, input logic [N-1:0] d, input logic m);
    shift_enable = se;
    in_valid     = v;
    parallel_in  = d;
    msb_first    = m;
    #1;
    chk("model_in_ready", in_ready, !m_pend);
    @(posedge clk);
    model_step(se, v, d, m);
    @(negedge clk);
    chk("model_serial", serial_out, model_serial());
    chk("model_busy", busy, m_active);
    chk("model_frame_done", frame_done, m_done);
    if (frame_done) done_seen++;
  endtask

  // n bit periods with a tick every 4th cycle, inputs idle.
  task automatic run_ticks(input int n, input logic m);
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, '0, m);
      cyc(1'b1, 1'b0, '0, m);
    end
  endtask

  typedef struct {
    logic [N-1:0] word;
    logic         msb;
    logic [N-1:0] exp_seq;  // emitted bits, first bit in the top position
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [N-1:0]  got;
    logic [15:0]   got16;
    bit            nogap;

    checks = 0;
    failures = 0;
    done_seen = 0;
    n_rst = 1'b0;
    shift_enable = 1'b0;
    in_valid = 1'b0;
    parallel_in = '0;
    msb_first = 1'b0;
    model_reset();

    vecs[0] = '{word: 8'hA5, msb: 1'b1, exp_seq: 8'b1010_0101};
    vecs[1] = '{word: 8'hA5, msb: 1'b0, exp_seq: 8'b1010_0101};
    vecs[2] = '{word: 8'h01, msb: 1'b1, exp_seq: 8'b0000_0001};
    vecs[3] = '{word: 8'h01, msb: 1'b0, exp_seq: 8'b1000_0000};
    vecs[4] = '{word: 8'hC1, msb: 1'b0, exp_seq: 8'b1000_0011};
    vecs[5] = '{word: 8'h0F, msb: 1'b1, exp_seq: 8'b0000_1111};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_serial", serial_out, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", frame_done, 1'b0);
    chk("reset_ready", in_ready, 1'b1);
    @(negedge clk);
    n_rst = 1'b1;

    // ---- table: single frames, msb_first input toggled mid-frame ----
    foreach (vecs[i]) begin
      done_seen = 0;
      cyc(1'b0, 1'b1, vecs[i].word, vecs[i].msb);
      got = '0;
      for (int b = 0; b < N; b++) begin
        got[N-1-b] = serial_out;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, '0, ~vecs[i].msb);
        cyc(1'b1, 1'b0, '0, ~vecs[i].msb);
      end
      chk("table_done_pulse", frame_done, 1'b1);
      cyc(1'b0, 1'b0, '0, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b0);
      chk("table_sequence", got, vecs[i].exp_seq);
      chk("table_done_count", done_seen, 1);
      chk("table_idle_serial", serial_out, 1'b1);
      chk("table_idle_busy", busy, 1'b0);
    end

    // ---- back-to-back through the holding buffer ----
    done_seen = 0;
    nogap = 1;
    cyc(1'b0, 1'b1, 8'hF0, 1'b1);
    cyc(1'b0, 1'b1, 8'h0F, 1'b0);
    chk("b2b_ready_low", in_ready, 1'b0);
    got16 = '0;
    for (int b = 0; b < 2*N; b++) begin
      got16[2*N-1-b] = serial_out;
      if (busy !== 1'b1) nogap = 0;
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, '0, 1'b1);
      cyc(1'b1, 1'b0, '0, 1'b1);
    end
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("b2b_sequence", got16, 16'hF0F0);
    chk("b2b_no_gap", nogap, 1'b1);
    chk("b2b_done_count", done_seen, 2);
    chk("b2b_idle_serial", serial_out, 1'b1);
    chk("b2b_ready_back", in_ready, 1'b1);

    // ---- frame-end bypass: accept exactly on the last tick ----
    cyc(1'b0, 1'b1, 8'h55, 1'b1);
    run_ticks(N-1, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b1, 8'h81, 1'b1);
    chk("bypass_done", frame_done, 1'b1);
    chk("bypass_busy", busy, 1'b1);
    chk("bypass_first_bit", serial_out, 1'b1);
    run_ticks(1, 1'b1);
    chk("bypass_second_bit", serial_out, 1'b0);
    run_ticks(N-1, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    chk("bypass_idle", serial_out, 1'b1);

    // ---- ticks ignored in IDLE; tick in the accept cycle ----
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b0, '0, 1'b0);
      chk("idle_tick_serial", serial_out, 1'b1);
    end
    cyc(1'b1, 1'b1, 8'h40, 1'b1);
    chk("accept_tick_first", serial_out, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, '0, 1'b1);
    chk("accept_tick_held", serial_out, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b1);
    chk("accept_tick_second", serial_out, 1'b1);
    run_ticks(N-1, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0);

    // ---- reset mid-frame ----
    cyc(1'b0, 1'b1, 8'hC3, 1'b1);
    cyc(1'b0, 1'b1, 8'h3C, 1'b0);
    run_ticks(3, 1'b1);
    n_rst = 1'b0;
    #1;
    chk("midreset_serial", serial_out, 1'b1);
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_ready", in_ready, 1'b1);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    done_seen = 0;
    run_ticks(N+2, 1'b1);
    chk("midreset_no_done", done_seen, 0);

    // ---- random traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
          N'($urandom), ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
